conv_output_seq: RTL and testbench

- Frame sequencer and buffer between the multiplier result stream and the convolution output stream.
- Accepts a frame-count command and admits exactly that many output frames of OUT_DIM*OUT_DIM beats each.
- Regenerates `last` from its own beat counter, checks the upstream `mult_last` marker, and decouples the two sides with a 2-entry skid buffer.
- Reports `busy`, `done` and a sticky framing error.

---
 rtl/conv_output_seq.sv | 169 ++++++++++++++++
 tb/tb_conv_output_seq.sv | 568 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_output_seq.sv
// Output sequencer for the convolution engine: admits num_frames frames of
// OUT_DIM*OUT_DIM beats, regenerates last, and checks mult_last.
// Optional macro CONV_OUT_RELU_EN clamps negative beats to zero at buffer push.
module conv_output_seq #(
    parameter int WIDTH       = 32,
    parameter int CONV_SIZE   = 28,
    parameter int KERNEL_SIZE = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [7:0]       num_frames,
    output logic             busy,
    output logic             done,
    output logic             err_last,
    input  logic             mult_valid,
    output logic             mult_ready,
    input  logic [WIDTH-1:0] mult_data,
    input  logic             mult_last,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             last,
    input  logic             ready
);
    localparam int OUT_DIM = CONV_SIZE - KERNEL_SIZE + 1;
    localparam int BEATS   = OUT_DIM * OUT_DIM;
    localparam int BCW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [BCW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;
    logic [7:0]       frames_q, frames_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] buf_data_q [2];
    logic [WIDTH-1:0] buf_data_d [2];
    logic [1:0]       buf_last_q, buf_last_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;

    logic             accept;
    logic             pop;
    logic             beat_is_last;
    logic             frame_is_last;
    logic [WIDTH-1:0] push_data;

    // Ready depends only on state and occupancy, never on downstream ready.
    assign mult_ready    = (state_q == S_RUN) && (count_q != 2'd2);
    assign accept        = mult_valid && mult_ready;
    assign pop           = (count_q != 2'd0) && ready;
    assign beat_is_last  = (beat_cnt_q == LAST_BEAT);
    assign frame_is_last = (frame_cnt_q == frames_q - 8'd1);

`ifdef CONV_OUT_RELU_EN
    assign push_data = mult_data[WIDTH-1] ? '0 : mult_data;
`else
    assign push_data = mult_data;
`endif

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        frame_cnt_d = frame_cnt_q;
        frames_d    = frames_q;
        err_d       = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    if (num_frames != 8'd0) begin
                        frames_d    = num_frames;
                        beat_cnt_d  = '0;
                        frame_cnt_d = 8'd0;
                        state_d     = S_RUN;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (accept) begin
                    // Mismatched marker is flagged, but the beat still goes out.
                    if (mult_last != beat_is_last) begin
                        err_d = 1'b1;
                    end
                    if (beat_is_last) begin
                        beat_cnt_d  = '0;
                        frame_cnt_d = frame_cnt_q + 8'd1;
                        if (frame_is_last) begin
                            state_d = S_DRAIN;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (count_q == 2'd0) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        buf_data_d = buf_data_q;
        buf_last_d = buf_last_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (accept) begin
            buf_data_d[wr_ptr_q] = push_data;
            buf_last_d[wr_ptr_q] = beat_is_last;
            wr_ptr_d             = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({accept, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            beat_cnt_q  <= '0;
            frame_cnt_q <= 8'd0;
            frames_q    <= 8'd0;
            err_q       <= 1'b0;
            buf_last_q  <= 2'b00;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                buf_data_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            frames_q    <= frames_d;
            err_q       <= err_d;
            buf_last_q  <= buf_last_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            for (int i = 0; i < 2; i++) begin
                buf_data_q[i] <= buf_data_d[i];
            end
        end
    end

    assign busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done     = (state_q == S_DONE);
    assign err_last = err_q;
    assign valid    = (count_q != 2'd0);
    assign data     = buf_data_q[rd_ptr_q];
    assign last     = buf_last_q[rd_ptr_q];

endmodule

// File: tb/tb_conv_output_seq.sv
// Self-checking bench for conv_output_seq (CONV_SIZE=4, KERNEL_SIZE=3 -> 4 beats/frame),
// comparing against a queue-based model of the frame/last/error rules.
module tb_conv_output_seq;
    localparam int WIDTH = 32;
    localparam int BEATS = 4;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        num_frames = 8'd0;
    logic              busy, done, err_last;
    logic              mult_valid = 1'b0;
    logic              mult_ready;
    logic [WIDTH-1:0]  mult_data = '0;
    logic              mult_last = 1'b0;
    logic              valid;
    logic [WIDTH-1:0]  data;
    logic              last;
    logic              ready = 1'b0;

    conv_output_seq #(.WIDTH(WIDTH), .CONV_SIZE(4), .KERNEL_SIZE(3)) dut (
        .clk(clk), .rstn(rstn), .start(start), .num_frames(num_frames),
        .busy(busy), .done(done), .err_last(err_last),
        .mult_valid(mult_valid), .mult_ready(mult_ready), .mult_data(mult_data),
        .mult_last(mult_last), .valid(valid), .data(data), .last(last), .ready(ready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- monitor: output beats, stall stability, done pulses
    logic [WIDTH-1:0] got_d[$];
    logic             got_l[$];
    int               got_c[$];
    int               done_cnt = 0, done_cyc = 0, stall_viol = 0, mr_low_cnt = 0;
    bit               stalled = 0;
    logic [WIDTH-1:0] st_data;
    logic             st_last;

    initial forever begin
        @(negedge clk);
        if (rstn) begin
            if (stalled && !(valid === 1'b1 && data === st_data && last === st_last))
                stall_viol++;
            if (valid && ready) begin
                got_d.push_back(data);
                got_l.push_back(last);
                got_c.push_back(cyc);
            end
            stalled = valid && !ready;
            st_data = data;
            st_last = last;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (busy && !mult_ready) mr_low_cnt++;
        end else begin
            stalled = 0;
        end
    end

    // ---------------- downstream ready driver: 0 always, 1 toggle, 2 random, 3 hold low
    int ready_mode = 3;
    initial forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       ready = 1'b1;
            1:       ready = ~ready;
            2:       ready = 1'($urandom_range(0, 1));
            default: ready = 1'b0;
        endcase
    end

    // ---------------- stimulus and reference model
    logic [WIDTH-1:0] in_vals[$];
    bit               in_mls[$];
    logic [WIDTH-1:0] exp_d[$];
    bit               exp_l[$];
    bit               exp_err;

    function automatic logic [WIDTH-1:0] relu_m(input logic [WIDTH-1:0] v);
`ifdef CONV_OUT_RELU_EN
        return ($signed(v) < 0) ? '0 : v;
`else
        return v;
`endif
    endfunction

    // Every accepted beat comes out once, in order; last marks every BEATS-th beat.
    function automatic void build_expected();
        exp_d.delete();
        exp_l.delete();
        exp_err = 0;
        for (int i = 0; i < in_vals.size(); i++) begin
            exp_d.push_back(relu_m(in_vals[i]));
            exp_l.push_back((i % BEATS) == BEATS - 1);
            if (in_mls[i] != ((i % BEATS) == BEATS - 1)) exp_err = 1;
        end
    endfunction

    task automatic clear_mon();
        got_d.delete();
        got_l.delete();
        got_c.delete();
        done_cnt = 0;
        stall_viol = 0;
        mr_low_cnt = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(input int nf);
        start = 1'b1;
        num_frames = 8'(nf);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [WIDTH-1:0] v, input bit ml, output bit ok);
        mult_valid = 1'b1;
        mult_data = v;
        mult_last = ml;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (mult_ready) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        mult_valid = 1'b0;
    endtask

    task automatic feed(input int gap_max, output int timeouts);
        bit ok;
        timeouts = 0;
        for (int i = 0; i < in_vals.size(); i++) begin
            send_beat(in_vals[i], in_mls[i], ok);
            if (!ok) timeouts++;
            if (gap_max > 0) idle($urandom_range(0, gap_max));
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load_seq(input int nbeats);
        in_vals.delete();
        in_mls.delete();
        for (int i = 0; i < nbeats; i++) begin
            in_vals.push_back(WIDTH'(i + 1));
            in_mls.push_back((i % BEATS) == BEATS - 1);
        end
    endtask

    // ---------------- scenarios
    task automatic test_reset();
        #12;
        n_cmp++;
        if ({busy, done, err_last, valid, last, mult_ready} !== 6'b0 || data !== '0) begin
            n_err++;
            $display("FAIL reset_state: busy=%b done=%b err=%b valid=%b last=%b mready=%b data=%h, want all 0",
                     busy, done, err_last, valid, last, mult_ready, data);
        end
        @(negedge clk);
        rstn = 1'b1;
        idle(2);
        n_cmp++;
        if ({busy, done, err_last, valid, mult_ready} !== 5'b0) begin
            n_err++;
            $display("FAIL post_reset_idle: busy=%b done=%b err=%b valid=%b mready=%b, want 0",
                     busy, done, err_last, valid, mult_ready);
        end
    endtask

    task automatic test_nominal();
        int to;
        bit ok;
        ready_mode = 0;
        idle(1);
        clear_mon();
        load_seq(8);
        build_expected();
        do_start(2);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL nominal_busy: got %b want 1", busy);
        end
        feed(0, to);
        wait_done(ok);
        n_cmp++;
        if (to != 0 || !ok) begin
            n_err++;
            $display("FAIL nominal_timeout: feed_timeouts=%0d done_seen=%0d want 0/1", to, ok);
        end
        n_cmp++;
        if (got_d.size() != exp_d.size()) begin
            n_err++;
            $display("FAIL nominal_count: got %0d beats want %0d", got_d.size(), exp_d.size());
        end else begin
            for (int i = 0; i < exp_d.size(); i++) begin
                n_cmp++;
                if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                    n_err++;
                    $display("FAIL nominal_beat%0d: got %h/%b want %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
                end
            end
            for (int i = 1; i < got_c.size(); i++) begin
                n_cmp++;
                if (got_c[i] - got_c[i-1] != 1) begin
                    n_err++;
                    $display("FAIL nominal_rate%0d: gap %0d cycles want 1", i, got_c[i] - got_c[i-1]);
                end
            end
            // Final pop empties the buffer; DRAIN sees empty next cycle, DONE the one after.
            n_cmp++;
            if (done_cyc - got_c[got_c.size()-1] != 2 || done_cnt != 1) begin
                n_err++;
                $display("FAIL nominal_done: delay %0d pulses %0d want 2/1",
                         done_cyc - got_c[got_c.size()-1], done_cnt);
            end
        end
        n_cmp++;
        if (err_last !== 1'b0) begin
            n_err++;
            $display("FAIL nominal_err: got %b want 0", err_last);
        end
    endtask

    task automatic test_backpressure();
        int to;
        bit ok;
        ready_mode = 1;
        idle(1);
        clear_mon();
        load_seq(8);
        build_expected();
        do_start(2);
        feed(0, to);
        wait_done(ok);
        n_cmp++;
        if (to != 0 || !ok) begin
            n_err++;
            $display("FAIL bp_timeout: feed_timeouts=%0d done_seen=%0d want 0/1", to, ok);
        end
        n_cmp++;
        if (got_d.size() != exp_d.size()) begin
            n_err++;
            $display("FAIL bp_count: got %0d beats want %0d", got_d.size(), exp_d.size());
        end else begin
            for (int i = 0; i < exp_d.size(); i++) begin
                n_cmp++;
                if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                    n_err++;
                    $display("FAIL bp_beat%0d: got %h/%b want %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
                end
            end
        end
        n_cmp++;
        if (stall_viol != 0) begin
            n_err++;
            $display("FAIL bp_stable: got %0d unstable stalls want 0", stall_viol);
        end
        n_cmp++;
        if (mr_low_cnt == 0) begin
            n_err++;
            $display("FAIL bp_mready_low: got %0d busy cycles with mult_ready low want >0", mr_low_cnt);
        end
    endtask

    task automatic test_framing();
        bit ok;
        int to;
        ready_mode = 0;
        idle(1);
        clear_mon();
        in_vals.delete();
        in_mls.delete();
        for (int i = 0; i < 4; i++) in_vals.push_back($urandom);
        in_mls = '{0, 1, 0, 0};
        build_expected();
        do_start(1);
        to = 0;
        send_beat(in_vals[0], in_mls[0], ok);
        if (!ok) to++;
        n_cmp++;
        if (err_last !== 1'b0) begin
            n_err++;
            $display("FAIL frame_err_beat1: got %b want 0", err_last);
        end
        send_beat(in_vals[1], in_mls[1], ok);
        if (!ok) to++;
        n_cmp++;
        if (err_last !== 1'b1) begin
            n_err++;
            $display("FAIL frame_err_beat2: got %b want 1", err_last);
        end
        send_beat(in_vals[2], in_mls[2], ok);
        if (!ok) to++;
        send_beat(in_vals[3], in_mls[3], ok);
        if (!ok) to++;
        wait_done(ok);
        n_cmp++;
        if (to != 0 || !ok) begin
            n_err++;
            $display("FAIL frame_timeout: feed_timeouts=%0d done_seen=%0d want 0/1", to, ok);
        end
        n_cmp++;
        if (err_last !== exp_err) begin
            n_err++;
            $display("FAIL frame_err_sticky: got %b want %b", err_last, exp_err);
        end
        n_cmp++;
        if (got_d.size() != 4) begin
            n_err++;
            $display("FAIL frame_count: got %0d beats want 4", got_d.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                    n_err++;
                    $display("FAIL frame_beat%0d: got %h/%b want %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
                end
            end
        end
    endtask

    task automatic test_zero_and_ignored();
        int to;
        bit ok;
        ready_mode = 0;
        clear_mon();
        do_start(0);
        n_cmp++;
        if (err_last !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL zero_clear: err=%b busy=%b want 0/0", err_last, busy);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL zero_done: done=%b busy=%b want 1/0", done, busy);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0 || got_d.size() != 0) begin
            n_err++;
            $display("FAIL zero_after: done=%b busy=%b beats=%0d want 0/0/0", done, busy, got_d.size());
        end
        idle(1);
        clear_mon();
        in_vals.delete();
        in_mls.delete();
        for (int i = 0; i < 4; i++) begin
            in_vals.push_back($urandom);
            in_mls.push_back(i == 3);
        end
        build_expected();
        do_start(1);
        to = 0;
        send_beat(in_vals[0], in_mls[0], ok);
        if (!ok) to++;
        do_start(5);
        for (int i = 1; i < 4; i++) begin
            send_beat(in_vals[i], in_mls[i], ok);
            if (!ok) to++;
        end
        wait_done(ok);
        idle(3);
        n_cmp++;
        if (to != 0 || !ok) begin
            n_err++;
            $display("FAIL ignored_timeout: feed_timeouts=%0d done_seen=%0d want 0/1", to, ok);
        end
        n_cmp++;
        if (got_d.size() != 4 || done_cnt != 1 || busy !== 1'b0 || mult_ready !== 1'b0) begin
            n_err++;
            $display("FAIL ignored_start: beats=%0d dones=%0d busy=%b mready=%b want 4/1/0/0",
                     got_d.size(), done_cnt, busy, mult_ready);
        end
    endtask

    task automatic test_reset_mid();
        int to;
        bit ok;
        ready_mode = 3;
        idle(1);
        clear_mon();
        do_start(1);
        send_beat(32'hA5A5_0001, 1'b0, ok);
        send_beat(32'h5A5A_0003, 1'b0, ok);
        #2;
        rstn = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, err_last, valid, last, mult_ready} !== 6'b0 || data !== '0) begin
            n_err++;
            $display("FAIL midreset_outputs: busy=%b done=%b err=%b valid=%b last=%b mready=%b data=%h want all 0",
                     busy, done, err_last, valid, last, mult_ready, data);
        end
        @(posedge clk);
        #3;
        rstn = 1'b1;
        ready_mode = 0;
        idle(2);
        clear_mon();
        in_vals.delete();
        in_mls.delete();
        for (int i = 0; i < 4; i++) begin
            in_vals.push_back(32'h100 + WIDTH'(i));
            in_mls.push_back(i == 3);
        end
        build_expected();
        do_start(1);
        feed(0, to);
        wait_done(ok);
        n_cmp++;
        if (to != 0 || !ok) begin
            n_err++;
            $display("FAIL midreset_timeout: feed_timeouts=%0d done_seen=%0d want 0/1", to, ok);
        end
        n_cmp++;
        if (got_d.size() != 4) begin
            n_err++;
            $display("FAIL midreset_count: got %0d beats want 4", got_d.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                    n_err++;
                    $display("FAIL midreset_beat%0d: got %h/%b want %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        int to, nf;
        bit ok;
        for (int it = 0; it < 4; it++) begin
            ready_mode = 2;
            idle(1);
            clear_mon();
            nf = $urandom_range(1, 3);
            in_vals.delete();
            in_mls.delete();
            for (int i = 0; i < nf * BEATS; i++) begin
                in_vals.push_back($urandom);
                in_mls.push_back((($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0) ^ ((i % BEATS) == BEATS - 1));
            end
            build_expected();
            do_start(nf);
            feed(2, to);
            wait_done(ok);
            n_cmp++;
            if (to != 0 || !ok) begin
                n_err++;
                $display("FAIL rand%0d_timeout: feed_timeouts=%0d done_seen=%0d want 0/1", it, to, ok);
            end
            n_cmp++;
            if (got_d.size() != exp_d.size()) begin
                n_err++;
                $display("FAIL rand%0d_count: got %0d beats want %0d", it, got_d.size(), exp_d.size());
            end else begin
                for (int i = 0; i < exp_d.size(); i++) begin
                    n_cmp++;
                    if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                        n_err++;
                        $display("FAIL rand%0d_beat%0d: got %h/%b want %h/%b", it, i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
                    end
                end
            end
            n_cmp++;
            if (err_last !== exp_err || stall_viol != 0 || done_cnt != 1) begin
                n_err++;
                $display("FAIL rand%0d_status: err=%b stalls=%0d dones=%0d want %b/0/1",
                         it, err_last, stall_viol, done_cnt, exp_err);
            end
            $display("rand%0d: frames=%0d beats=%0d err_exp=%0d", it, nf, exp_d.size(), exp_err);
        end
    endtask

`ifdef CONV_OUT_RELU_EN
    task automatic test_relu();
        int to;
        bit ok;
        logic [WIDTH-1:0] want [4];
        want = '{32'h0, 32'h5, 32'h0, 32'h7};
        ready_mode = 0;
        idle(1);
        clear_mon();
        in_vals.delete();
        in_mls.delete();
        in_vals = '{32'hFFFF_FFFF, 32'h5, 32'h8000_0000, 32'h7};
        in_mls = '{0, 0, 0, 1};
        do_start(1);
        feed(0, to);
        wait_done(ok);
        n_cmp++;
        if (got_d.size() != 4 || to != 0 || !ok) begin
            n_err++;
            $display("FAIL relu_count: got %0d beats done=%0d want 4/1", got_d.size(), ok);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (got_d[i] !== want[i]) begin
                    n_err++;
                    $display("FAIL relu_beat%0d: got %h want %h", i, got_d[i], want[i]);
                end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_nominal();
        $display("nominal done: compared=%0d", n_cmp);
        test_backpressure();
        $display("backpressure done: compared=%0d", n_cmp);
        test_framing();
        $display("framing done: compared=%0d", n_cmp);
        test_zero_and_ignored();
        $display("zero/ignored done: compared=%0d", n_cmp);
        test_reset_mid();
        $display("mid-reset done: compared=%0d", n_cmp);
        test_random();
`ifdef CONV_OUT_RELU_EN
        test_relu();
        $display("relu done: compared=%0d", n_cmp);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
